// File: rtl/jtroadf_snd_rx_if.sv
// Bus bundle between the main CPU side, the sound CPU side and the
// sound-data receive block.
//   main_cen   : main CPU bus clock enable (Q clock)
//   main_we    : sound-data chip select gated with a write
//   main_din   : main CPU write data
//   snd_irq    : sound interrupt request level from the main CPU latch
//   snd_cen    : sound CPU clock enable
//   snd_rd     : sound CPU latch-read strobe (one clk wide)
//   snd_iack   : sound CPU interrupt acknowledge (one clk wide)
//   latch_dout : sound data latch contents
//   int_n      : sound CPU interrupt, active low
//   timer      : free-running timer value
//   pending    : latch holds an unread byte
//   overrun    : sticky, a byte was overwritten before being read
interface jtroadf_snd_rx_if #(
    parameter int TIMER_W = 4
);
    logic               main_cen;
    logic               main_we;
    logic [7:0]         main_din;
    logic               snd_irq;
    logic               snd_cen;
    logic               snd_rd;
    logic               snd_iack;
    logic [7:0]         latch_dout;
    logic               int_n;
    logic [TIMER_W-1:0] timer;
    logic               pending;
    logic               overrun;

    // Driver side: the CPUs
    modport master (
        output main_cen, main_we, main_din, snd_irq,
        output snd_cen, snd_rd, snd_iack,
        input  latch_dout, int_n, timer, pending, overrun
    );

    // Receiver side: the sound-data block
    modport slave (
        input  main_cen, main_we, main_din, snd_irq,
        input  snd_cen, snd_rd, snd_iack,
        output latch_dout, int_n, timer, pending, overrun
    );
endinterface

// File: rtl/jtroadf_snd_rx.sv
// Sound-data receiver: main CPU -> sound CPU byte latch with pending and
// sticky overrun flags, edge-triggered sound interrupt with acknowledge,
// and a free-running prescaled timer clocked by snd_cen.
// Ports:
//   clk : system clock
//   rst : synchronous, active-high reset
//   bus : jtroadf_snd_rx_if.slave (see interface file for signal list)
module jtroadf_snd_rx #(
    parameter int TIMER_DIV = 1024,
    parameter int TIMER_W   = 4
) (
    input  logic            clk,
    input  logic            rst,
    jtroadf_snd_rx_if.slave bus
);
    localparam int PRE_W = $clog2(TIMER_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TIMER_DIV - 1);

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} irq_state_t;

    logic [7:0]         latch_q,     latch_d;
    logic               pending_q,   pending_d;
    logic               overrun_q,   overrun_d;
    logic               snd_irq_l_q, snd_irq_l_d;
    logic [PRE_W-1:0]   presc_q,     presc_d;
    logic [TIMER_W-1:0] timer_q,     timer_d;
    irq_state_t         state_q;
    logic               int_n_q;

    logic latch_wr;
    logic irq_rise;

    assign latch_wr = bus.main_cen & bus.main_we;
    // Rising edge is only seen on main_cen cycles, against the level
    // captured on the previous main_cen cycle.
    assign irq_rise = bus.main_cen & bus.snd_irq & ~snd_irq_l_q;

    always_comb begin
        latch_d     = latch_q;
        pending_d   = pending_q;
        overrun_d   = overrun_q;
        snd_irq_l_d = snd_irq_l_q;
        presc_d     = presc_q;
        timer_d     = timer_q;

        if (latch_wr) begin
            latch_d   = bus.main_din;
            // A write in the same cycle as a read wins, so pending stays set
            pending_d = 1'b1;
            // Overwrite counts as lost only if the reader did not take the
            // old byte in this same cycle.
            if (pending_q && !bus.snd_rd) begin
                overrun_d = 1'b1;
            end
        end else if (bus.snd_rd) begin
            pending_d = 1'b0;
        end

        if (bus.main_cen) begin
            snd_irq_l_d = bus.snd_irq;
        end

        if (bus.snd_cen) begin
            if (presc_q == PRE_MAX) begin
                presc_d = '0;
                timer_d = timer_q + 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            latch_q     <= 8'h00;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
            snd_irq_l_q <= 1'b0;
            presc_q     <= '0;
            timer_q     <= '0;
        end else begin
            latch_q     <= latch_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            snd_irq_l_q <= snd_irq_l_d;
            presc_q     <= presc_d;
            timer_q     <= timer_d;
        end
    end

    // Interrupt request machine; int_n is registered alongside the state.
    // Requests are not queued, and an edge coinciding with an ack wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            int_n_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (irq_rise) begin
                        state_q <= REQ;
                        int_n_q <= 1'b0;
                    end
                end
                REQ: begin
                    if (bus.snd_iack && !irq_rise) begin
                        state_q <= IDLE;
                        int_n_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    int_n_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.latch_dout = latch_q;
    assign bus.pending    = pending_q;
    assign bus.overrun    = overrun_q;
    assign bus.int_n      = int_n_q;
    assign bus.timer      = timer_q;
endmodule

// File: tb/tb_jtroadf_snd_rx.sv
module tb_jtroadf_snd_rx;
    localparam int TDIV = 4;
    localparam int TW   = 4;

    logic clk = 1'b0;
    logic rst;

    jtroadf_snd_rx_if #(.TIMER_W(TW)) bus();

    jtroadf_snd_rx #(.TIMER_DIV(TDIV), .TIMER_W(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: what the CPUs would observe
    bit [7:0] m_latch;
    bit       m_pend, m_ovr, m_req, m_prev;
    int       m_pulses;

    typedef struct {
        bit       cen, we;
        bit [7:0] din;
        bit       irq, rd, iack, scen;
        bit [7:0] e_latch;
        bit       e_pend, e_ovr, e_intn;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit cen, input bit we, input bit [7:0] din,
                         input bit irq, input bit rd, input bit iack, input bit scen);
        bus.main_cen = cen;
        bus.main_we  = we;
        bus.main_din = din;
        bus.snd_irq  = irq;
        bus.snd_rd   = rd;
        bus.snd_iack = iack;
        bus.snd_cen  = scen;
    endtask

    // Advance the model by the rules of the block for the inputs now applied
    task automatic model_edge();
        bit rise;
        if (rst) begin
            m_latch = 8'h00; m_pend = 0; m_ovr = 0; m_req = 0; m_prev = 0; m_pulses = 0;
        end else begin
            rise = bus.main_cen && bus.snd_irq && !m_prev;
            if (bus.main_cen) m_prev = bus.snd_irq;
            if (rise) m_req = 1;
            else if (bus.snd_iack) m_req = 0;
            if (bus.main_cen && bus.main_we) begin
                if (m_pend && !bus.snd_rd) m_ovr = 1;
                m_latch = bus.main_din;
                m_pend  = 1;
            end else if (bus.snd_rd) begin
                m_pend = 0;
            end
            if (bus.snd_cen) m_pulses++;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".latch"},   32'(bus.latch_dout), 32'(m_latch));
        chk({tag, ".pending"}, 32'(bus.pending),    32'(m_pend));
        chk({tag, ".overrun"}, 32'(bus.overrun),    32'(m_ovr));
        chk({tag, ".int_n"},   32'(bus.int_n),      32'(!m_req));
        chk({tag, ".timer"},   32'(bus.timer),      32'((m_pulses / TDIV) % (1 << TW)));
    endtask

    initial begin
        //           cen we din   irq rd iack scen  latch  pend ovr intn
        tbl[0]  = '{1, 1, 8'hA5, 0, 0, 0, 0, 8'hA5, 1, 0, 1};
        tbl[1]  = '{0, 0, 8'h00, 0, 0, 0, 0, 8'hA5, 1, 0, 1};
        tbl[2]  = '{0, 0, 8'h00, 0, 1, 0, 0, 8'hA5, 0, 0, 1};
        tbl[3]  = '{1, 1, 8'h44, 0, 0, 0, 0, 8'h44, 1, 0, 1};
        tbl[4]  = '{1, 1, 8'h55, 0, 1, 0, 0, 8'h55, 1, 0, 1};
        tbl[5]  = '{0, 1, 8'h66, 0, 1, 0, 0, 8'h55, 0, 0, 1};
        tbl[6]  = '{1, 1, 8'h11, 0, 0, 0, 0, 8'h11, 1, 0, 1};
        tbl[7]  = '{1, 1, 8'h22, 0, 0, 0, 0, 8'h22, 1, 1, 1};
        tbl[8]  = '{0, 0, 8'h00, 0, 1, 0, 0, 8'h22, 0, 1, 1};
        tbl[9]  = '{0, 0, 8'h00, 1, 0, 0, 0, 8'h22, 0, 1, 1};
        tbl[10] = '{1, 0, 8'h00, 1, 0, 0, 0, 8'h22, 0, 1, 0};
        tbl[11] = '{1, 0, 8'h00, 1, 0, 1, 0, 8'h22, 0, 1, 1};
        tbl[12] = '{1, 0, 8'h00, 0, 0, 0, 0, 8'h22, 0, 1, 1};
        tbl[13] = '{1, 0, 8'h00, 1, 0, 1, 0, 8'h22, 0, 1, 0};
        tbl[14] = '{0, 0, 8'h00, 1, 0, 1, 0, 8'h22, 0, 1, 1};
        tbl[15] = '{1, 0, 8'h00, 0, 0, 1, 0, 8'h22, 0, 1, 1};

        // Reset with enables active: outputs must still take reset values
        rst = 1'b1;
        drive(1, 1, 8'hFF, 1, 0, 0, 1);
        tick();
        tick();
        chk("rst.latch",   32'(bus.latch_dout), 32'h00);
        chk("rst.pending", 32'(bus.pending),    32'h0);
        chk("rst.overrun", 32'(bus.overrun),    32'h0);
        chk("rst.int_n",   32'(bus.int_n),      32'h1);
        chk("rst.timer",   32'(bus.timer),      32'h0);

        rst = 1'b0;
        drive(0, 0, 8'h00, 0, 0, 0, 0);
        tick();

        // Directed vectors
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].cen, tbl[i].we, tbl[i].din, tbl[i].irq,
                  tbl[i].rd, tbl[i].iack, tbl[i].scen);
            tick();
            chk($sformatf("vec%0d.latch", i),   32'(bus.latch_dout), 32'(tbl[i].e_latch));
            chk($sformatf("vec%0d.pending", i), 32'(bus.pending),    32'(tbl[i].e_pend));
            chk($sformatf("vec%0d.overrun", i), 32'(bus.overrun),    32'(tbl[i].e_ovr));
            chk($sformatf("vec%0d.int_n", i),   32'(bus.int_n),      32'(tbl[i].e_intn));
            chk($sformatf("vec%0d.timer", i),   32'(bus.timer),      32'h0);
        end

        // Held-high irq must not retrigger after the ack
        drive(1, 0, 8'h00, 0, 0, 0, 0); tick();
        drive(1, 0, 8'h00, 1, 0, 0, 0); tick();
        chk("hold.req", 32'(bus.int_n), 32'h0);
        drive(0, 0, 8'h00, 1, 0, 1, 0); tick();
        chk("hold.ack", 32'(bus.int_n), 32'h1);
        for (int i = 0; i < 100; i++) begin
            drive(1, 0, 8'h00, 1, 0, 0, 0); tick();
            chk("hold.int_n", 32'(bus.int_n), 32'h1);
        end

        // Timer: increments every TDIV pulses, back to 0 after 64 pulses
        rst = 1'b1; drive(0, 0, 8'h00, 0, 0, 0, 0); tick(); rst = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            drive(0, 0, 8'h00, 0, 0, 0, 1); tick();
            chk("timer.run", 32'(bus.timer), 32'((k / 4) % 16));
        end
        chk("timer.wrap", 32'(bus.timer), 32'h0);

        // Mid-operation reset with irq held high
        for (int k = 0; k < 28; k++) begin
            drive(0, 0, 8'h00, 0, 0, 0, 1); tick();
        end
        drive(1, 1, 8'h5A, 1, 0, 0, 0); tick();
        chk("mrst.pre_timer", 32'(bus.timer),   32'h7);
        chk("mrst.pre_int_n", 32'(bus.int_n),   32'h0);
        chk("mrst.pre_pend",  32'(bus.pending), 32'h1);
        rst = 1'b1;
        drive(1, 1, 8'hFF, 1, 0, 0, 1); tick();
        chk("mrst.latch",   32'(bus.latch_dout), 32'h00);
        chk("mrst.pending", 32'(bus.pending),    32'h0);
        chk("mrst.overrun", 32'(bus.overrun),    32'h0);
        chk("mrst.int_n",   32'(bus.int_n),      32'h1);
        chk("mrst.timer",   32'(bus.timer),      32'h0);
        rst = 1'b0;
        drive(0, 0, 8'h00, 1, 0, 0, 0); tick();
        chk("mrst.no_cen", 32'(bus.int_n), 32'h1);
        drive(1, 0, 8'h00, 1, 0, 0, 0); tick();
        chk("mrst.first_cen", 32'(bus.int_n), 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            bit irq_n;
            irq_n = bus.snd_irq;
            if ($urandom_range(0, 3) == 0) irq_n = ~irq_n;
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, 8'($urandom),
                  irq_n, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 1) == 1);
            tick();
            check_model("rand");
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/jtroadf_snd_rx.md
JTROADF_SND_RX -- requirements
Module: jtroadf_snd_rx

Interface
REQ-001 Parameter: TIMER_DIV, 1024, number of snd_cen pulses per timer increment; range 2..65536.
REQ-002 Parameter: TIMER_W, 4, width of the free-running timer readback.
REQ-003 Port: clk  in  1  system clock (24 MHz).
REQ-004 Port: rst  in  1  reset; synchronous, active-high.
REQ-005 Port: main_cen  in  1  main CPU bus clock enable (Q clock).
REQ-006 Port: snd_cen  in  1  sound CPU clock enable.
REQ-007 Port: main_we  in  1  main CPU write strobe to the sound data latch; it is the sound-data chip select gated with a write.
REQ-008 Port: main_din  in  8  main CPU write data.
REQ-009 Port: snd_irq  in  1  sound interrupt request level from the main CPU output latch.
REQ-010 Port: snd_rd  in  1  sound CPU latch-read strobe, one clk wide.
REQ-011 Port: snd_iack  in  1  sound CPU interrupt acknowledge, one clk wide.
REQ-012 Port: latch_dout  out  8  sound data latch contents.
REQ-013 Port: int_n  out  1  sound CPU interrupt, active low.
REQ-014 Port: timer  out  TIMER_W  free-running timer value.
REQ-015 Port: pending  out  1  latch holds a byte the sound CPU has not read.
REQ-016 Port: overrun  out  1  sticky flag; a byte was overwritten before it was read.

Function
REQ-017 Writes and snd_irq sampling SHALL occur only on clk edges where main_cen=1.
REQ-018 Latch write: when main_we and main_cen are both 1, latch_dout SHALL take main_din on the next clk edge.
REQ-019 latch_dout SHALL be driven directly from a register. It SHALL not be combinational from main_din.
REQ-020 pending set: pending SHALL go to 1 on each latch write.
REQ-021 pending clear: pending SHALL go to 0 on snd_rd.
REQ-022 Simultaneous latch write and snd_rd: latch_dout SHALL show the old byte during that cycle, the write SHALL win, and pending SHALL stay 1.
REQ-023 Overrun: a latch write while pending=1 and snd_rd=0 SHALL set overrun to 1. overrun SHALL clear only on reset.
REQ-024 IRQ edge detect: snd_irq SHALL be registered on main_cen into snd_irq_l. A rising edge SHALL be detected when snd_irq=1 and snd_irq_l=0 on a main_cen cycle.
REQ-025 The IRQ state machine SHALL have two states, IDLE (int_n=1) and REQ (int_n=0).
REQ-026 IDLE SHALL move to REQ on a detected rising edge.
REQ-027 REQ SHALL move to IDLE on snd_iack.
REQ-028 Additional rising edges while in REQ SHALL have no effect; requests SHALL not be queued.
REQ-029 A rising edge and snd_iack in the same cycle SHALL leave the machine in REQ (int_n=0). The edge wins.
REQ-030 snd_iack while in IDLE SHALL be ignored.
REQ-031 A held-high snd_irq SHALL not retrigger. A new request SHALL require snd_irq to return low on a main_cen cycle and then rise again.
REQ-032 int_n SHALL change one clk after the triggering edge or ack cycle.
REQ-033 Timer prescaler: a counter of width clog2(TIMER_DIV) SHALL count snd_cen pulses.
REQ-034 On a snd_cen pulse with the prescaler at TIMER_DIV-1, the prescaler SHALL wrap to 0 and timer SHALL increment modulo 2^TIMER_W.
REQ-035 timer SHALL wrap from all-ones to 0 with no flag and no stall.
REQ-036 The timer SHALL be independent of all latch and IRQ activity.

Reset
REQ-037 While rst=1 at a clk edge, the block SHALL load latch_dout=8'h00, pending=0, overrun=0, int_n=1, state IDLE, snd_irq_l=0, prescaler=0 and timer=0.
REQ-038 Reset applied mid-operation SHALL abandon any REQ state or partial prescaler count immediately. This applies even with snd_irq held high.
REQ-039 After reset, a snd_irq level that is already 1 SHALL register as a rising edge on the first main_cen cycle. This follows from snd_irq_l resetting to 0.
REQ-040 No output SHALL depend on main_cen or snd_cen during reset.

Verification
REQ-041 Scenario: write 8'hA5 with main_cen=1, then snd_rd two cycles later -> latch_dout=8'hA5 one clk after the write; pending 1 then 0; overrun=0.
REQ-042 Scenario: write 8'h11, then 8'h22 with no read between -> latch_dout=8'h22, pending=1, overrun=1; overrun stays 1 after a subsequent snd_rd.
REQ-043 Scenario: snd_irq 0->1 on a main_cen cycle -> int_n=0 one clk later. snd_iack -> int_n=1. snd_irq held 1 for 100 main_cen cycles -> int_n stays 1.
REQ-044 Scenario: snd_iack coincident with a fresh snd_irq rising edge -> int_n remains 0.
REQ-045 Scenario: TIMER_DIV=4 with continuous snd_cen -> timer increments every 4 pulses and reads 0 again after exactly 64 pulses.
REQ-046 Scenario: assert rst with int_n=0, pending=1, timer=7 -> all outputs take reset values on the next clk. With snd_irq still 1, int_n=0 again one clk after the first post-reset main_cen.
